acc_wm_streamer: RTL and testbench
==================================

ACC_WM_STREAMER -- requirements
Module: acc_wm_streamer

Interface
REQ-001 SHALL have ports: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: acc_start  input  1  level request from sleep-mode controller; held high until acc_done seen.
REQ-004 SHALL have ports: word_count  input  7  number of WM words to stream; sampled on accepted start.
REQ-005 SHALL have ports: wm_raddr  output  7  weight-memory read address.
REQ-006 SHALL have ports: wm_rdata  input  64  weight-memory read data, valid exactly 1 cycle after wm_raddr.
REQ-007 SHALL have ports: px_data  output  8  streamed byte to MAC array.
REQ-008 SHALL have ports: px_valid  output  1  px_data valid.
REQ-009 SHALL have ports: px_ready  input  1  MAC array accepts byte; transfer = px_valid & px_ready.
REQ-010 SHALL have ports: px_last  output  1  marks final byte of final word.
REQ-011 SHALL have ports: acc_busy  output  1  run in progress.
REQ-012 SHALL have ports: acc_done  output  1  run complete; held until acc_start low.

Function
REQ-013 SHALL implement FSM IDLE, FETCH, WAIT, STREAM, DONE.
REQ-014 IDLE: acc_start=1 at edge N -> FETCH at N+1; word_count latched, word index=0, wm_raddr=0, acc_busy=1.
REQ-015 FETCH -> WAIT unconditionally; WAIT captures wm_rdata into shift buffer -> STREAM.
REQ-016 First px_valid SHALL assert 3 cycles after the start edge (N+3).
REQ-017 STREAM emits bytes LSB first (bits 7:0 first, 63:56 last), 8 transfers per word.
REQ-018 px_valid=1 and px_data, px_last SHALL stay stable while px_ready=0; no byte dropped or duplicated.
REQ-019 After 8th transfer: more words -> FETCH with wm_raddr = word index+1; else DONE.
REQ-020 px_last=1 only on byte 7 of word word_count-1.
REQ-021 DONE: acc_busy=0, acc_done=1; acc_start=0 -> IDLE next cycle with acc_done=0.
REQ-022 word_count=0 -> IDLE to DONE via FETCH only, no WM read data used, no px_valid.
REQ-023 acc_start falling while busy SHALL be ignored; run completes.
REQ-024 wm_raddr width rule: word index 7 bits, word_count up to 127, no wrap.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and all outputs to 0: wm_raddr, px_data, px_valid, px_last, acc_busy, acc_done; counters and buffers cleared.
REQ-026 Reset mid-run SHALL abandon the run; after release, a new acc_start begins from word 0.

Configuration
REQ-027 Macro WM_PREFETCH_EN SHALL select word prefetch.
REQ-028 Without WM_PREFETCH_EN: 2 bubble cycles (FETCH, WAIT) between words; word_count=W, px_ready=1 -> last transfer at N+2+10W-2.
REQ-029 With WM_PREFETCH_EN: a second 64-bit holding register; next word read issued during STREAM of the current word; with px_ready=1, bytes contiguous, last transfer at N+2+8W.
REQ-030 Both variants SHALL yield identical byte sequence, px_last and done behaviour.

Structure
REQ-031 Shared package acc_pkg SHALL hold WM_ADDR_W=7, WM_DATA_W=64, PX_W=8, BYTES_PER_WORD=8, and the FSM state typedef.
REQ-032 One sub-module wm_word_unpacker SHALL hold the 64-bit shift buffer, byte counter and valid/ready logic.

Verification
REQ-033 word_count=1, wm word0=0x0807060504030201, px_ready=1 -> px_data 01..08 on N+3..N+10, px_last on 08, acc_done next.
REQ-034 word_count=3, px_ready toggling 1/0 -> 24 bytes in order, each held stable while ready=0, px_last on byte 24.
REQ-035 word_count=0 -> no px_valid, acc_done=1 within 2 cycles, cleared 1 cycle after acc_start=0.
REQ-036 rst_n=0 during word 1 of 3 -> all outputs 0 immediately; restart streams from word 0 address 0.
REQ-037 WM_PREFETCH_EN on/off, word_count=4, px_ready=1 -> last transfer at N+34 versus N+40, identical data.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared widths and FSM state type for the accelerator weight-memory streamer.
package acc_pkg;

    localparam int unsigned WM_ADDR_W      = 7;
    localparam int unsigned WM_DATA_W      = 64;
    localparam int unsigned PX_W           = 8;
    localparam int unsigned BYTES_PER_WORD = 8;
    localparam int unsigned BYTE_IDX_W     = 3;

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_STREAM,
        ST_DONE
    } acc_state_t;

endpackage

// File: rtl/wm_word_unpacker.sv
// Holds one 64-bit weight word and hands it out LSB byte first over a valid/ready link.
module wm_word_unpacker
    import acc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WM_DATA_W-1:0] load_data,
    input  logic                 last_word,
    input  logic                 px_ready,
    output logic [PX_W-1:0]      px_data,
    output logic                 px_valid,
    output logic                 px_last,
    output logic                 word_done
);

    logic [WM_DATA_W-1:0]  shift_buf;
    logic [BYTE_IDX_W-1:0] byte_cnt;
    logic                  valid;
    logic                  xfer;

    assign xfer      = valid && px_ready;
    assign word_done = xfer && (byte_cnt == LAST_BYTE);
    assign px_data   = shift_buf[PX_W-1:0];
    assign px_valid  = valid;
    assign px_last   = valid && last_word && (byte_cnt == LAST_BYTE);

    // A load on the same edge as the final transfer takes priority, so words can run back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_buf <= '0;
            byte_cnt  <= '0;
            valid     <= 1'b0;
        end else if (load) begin
            shift_buf <= load_data;
            byte_cnt  <= '0;
            valid     <= 1'b1;
        end else if (xfer) begin
            shift_buf <= shift_buf >> PX_W;
            byte_cnt  <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/acc_wm_streamer.sv
// Streams word_count weight-memory words to the MAC array as bytes on request.
// Optional macro WM_PREFETCH_EN: read the next word during the current stream to remove bubbles.
module acc_wm_streamer
    import acc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 acc_start,
    input  logic [WM_ADDR_W-1:0] word_count,
    output logic [WM_ADDR_W-1:0] wm_raddr,
    input  logic [WM_DATA_W-1:0] wm_rdata,
    output logic [PX_W-1:0]      px_data,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic                 px_last,
    output logic                 acc_busy,
    output logic                 acc_done
);

    acc_state_t           state, state_nx;
    logic [WM_ADDR_W-1:0] count;
    logic [WM_ADDR_W-1:0] word_idx;
    logic                 last_word;
    logic                 word_done;
    logic                 load;
    logic [WM_DATA_W-1:0] load_data;

    assign last_word = (word_idx == count - 1'b1);
    assign acc_busy  = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_STREAM);
    assign acc_done  = (state == ST_DONE);

`ifdef WM_PREFETCH_EN
    logic [WM_DATA_W-1:0] hold_buf;
    logic                 hold_valid;
    logic [1:0]           pf_cnt;

    assign load      = (state == ST_WAIT) ||
                       ((state == ST_STREAM) && word_done && !last_word && hold_valid);
    assign load_data = (state == ST_WAIT) ? wm_rdata : hold_buf;
`else
    assign load      = (state == ST_WAIT);
    assign load_data = wm_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (acc_start) state_nx = ST_FETCH;
            ST_FETCH:  state_nx = (count == '0) ? ST_DONE : ST_WAIT;
            ST_WAIT:   state_nx = ST_STREAM;
            ST_STREAM: begin
                if (word_done) begin
`ifdef WM_PREFETCH_EN
                    if (last_word)       state_nx = ST_DONE;
                    else if (!hold_valid) state_nx = ST_FETCH;
`else
                    state_nx = last_word ? ST_DONE : ST_FETCH;
`endif
                end
            end
            ST_DONE:   if (!acc_start) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            word_idx <= '0;
            wm_raddr <= '0;
`ifdef WM_PREFETCH_EN
            hold_buf   <= '0;
            hold_valid <= 1'b0;
            pf_cnt     <= '0;
`endif
        end else begin
`ifdef WM_PREFETCH_EN
            // Read data is valid one cycle after the address is sampled, so capture two edges after issue.
            if (pf_cnt != 2'd0) begin
                pf_cnt <= pf_cnt - 2'd1;
                if (pf_cnt == 2'd1) begin
                    hold_buf   <= wm_rdata;
                    hold_valid <= 1'b1;
                end
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (acc_start) begin
                        count    <= word_count;
                        word_idx <= '0;
                        wm_raddr <= '0;
                    end
                end
`ifdef WM_PREFETCH_EN
                ST_WAIT: begin
                    hold_valid <= 1'b0;
                    if (!last_word) begin
                        wm_raddr <= word_idx + 1'b1;
                        pf_cnt   <= 2'd2;
                    end
                end
`endif
                ST_STREAM: begin
                    if (word_done && !last_word) begin
                        word_idx <= word_idx + 1'b1;
`ifdef WM_PREFETCH_EN
                        // Without a captured word the address already points at word_idx+1 for the refetch.
                        if (hold_valid) begin
                            hold_valid <= 1'b0;
                            if (word_idx + 2'd2 != count) begin
                                wm_raddr <= word_idx + 2'd2;
                                pf_cnt   <= 2'd2;
                            end
                        end
`else
                        wm_raddr <= word_idx + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    wm_word_unpacker u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .last_word (last_word),
        .px_ready  (px_ready),
        .px_data   (px_data),
        .px_valid  (px_valid),
        .px_last   (px_last),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_acc_wm_streamer.sv
// Directed self-checking bench for acc_wm_streamer; weight memory modelled as a 1-cycle synchronous read.
module tb_acc_wm_streamer;
    import acc_pkg::*;

`ifdef WM_PREFETCH_EN
    localparam int LAST4 = 34;
`else
    localparam int LAST4 = 40;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        acc_start;
    logic [6:0]  word_count;
    logic [6:0]  wm_raddr;
    logic [63:0] wm_rdata;
    logic [7:0]  px_data;
    logic        px_valid;
    logic        px_ready;
    logic        px_last;
    logic        acc_busy;
    logic        acc_done;

    logic [63:0] mem [128];
    int          edge_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    logic [7:0]  q_data[$];
    logic        q_last[$];
    int          q_edge[$];
    int          valid_cnt = 0;
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;

    always #5 clk = ~clk;

    acc_wm_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_start  (acc_start),
        .word_count (word_count),
        .wm_raddr   (wm_raddr),
        .wm_rdata   (wm_rdata),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_last    (px_last),
        .acc_busy   (acc_busy),
        .acc_done   (acc_done)
    );

    always @(posedge clk) begin
        wm_rdata <= mem[wm_raddr];
        edge_cnt <= edge_cnt + 1;
    end

    // Inputs only move 1ns after a rising edge, so the falling edge sees what the next rising edge will.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(px_valid && px_data === prev_data && px_last === prev_last))
                stall_err++;
            if (px_valid) valid_cnt++;
            if (px_valid && px_ready) begin
                q_data.push_back(px_data);
                q_last.push_back(px_last);
                q_edge.push_back(edge_cnt + 1);
            end
            prev_stall = px_valid && !px_ready;
            prev_data  = px_data;
            prev_last  = px_last;
        end
    end

    function automatic logic [7:0] exp_byte(input int w, input int b);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(w + 0);
        lo = 4'(b + 1);
        return {hi, lo};
    endfunction

    function automatic int last_edge();
        return (q_edge.size() > 0) ? q_edge[q_edge.size() - 1] : -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit toggle_ready = 1'b0);
        @(posedge clk);
        #1;
        if (toggle_ready) px_ready = ~px_ready;
    endtask

    task automatic start_run(input int words, output int n);
        q_data.delete();
        q_last.delete();
        q_edge.delete();
        valid_cnt  = 0;
        stall_err  = 0;
        word_count = 7'(words);
        acc_start  = 1'b1;
        n = edge_cnt + 1;
    endtask

    task automatic wait_done(input string tag, input bit toggle_ready, output int at_edge);
        at_edge = -1;
        for (int i = 0; i < 300; i++) begin
            tick(toggle_ready);
            if (acc_done) begin
                at_edge = edge_cnt;
                break;
            end
        end
        check({tag, " done seen"}, 64'(acc_done), 64'(1));
    endtask

    task automatic check_stream(input int words, input string tag);
        check({tag, " byte count"}, 64'(q_data.size()), 64'(words * 8));
        for (int i = 0; i < q_data.size() && i < words * 8; i++) begin
            check($sformatf("%s byte%0d", tag, i), {55'd0, q_last[i], q_data[i]},
                  {55'd0, (i == words * 8 - 1), exp_byte(i / 8, i % 8)});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wm_raddr"}, 64'(wm_raddr), 64'(0));
        check({tag, " px_data"},  64'(px_data),  64'(0));
        check({tag, " px_valid"}, 64'(px_valid), 64'(0));
        check({tag, " px_last"},  64'(px_last),  64'(0));
        check({tag, " acc_busy"}, 64'(acc_busy), 64'(0));
        check({tag, " acc_done"}, 64'(acc_done), 64'(0));
    endtask

    initial begin
        int n;
        int d;

        foreach (mem[i]) mem[i] = '0;
        mem[0] = 64'h0807060504030201;
        mem[1] = 64'h1817161514131211;
        mem[2] = 64'h2827262524232221;
        mem[3] = 64'h3837363534333231;

        rst_n      = 1'b0;
        acc_start  = 1'b0;
        word_count = '0;
        px_ready   = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // Single word, always ready.
        start_run(1, n);
        tick();
        check("A busy at N", 64'(acc_busy), 64'(1));
        check("A raddr at N", 64'(wm_raddr), 64'(0));
        tick();
        check("A no valid at N+1", 64'(px_valid), 64'(0));
        wait_done("A", 1'b0, d);
        check("A done edge", 64'(d), 64'(n + 10));
        check("A first xfer edge", 64'(q_edge.size() > 0 ? q_edge[0] : -1), 64'(n + 3));
        check("A last xfer edge", 64'(last_edge()), 64'(n + 10));
        check_stream(1, "A");
        check("A busy in done", 64'(acc_busy), 64'(0));
        acc_start = 1'b0;
        tick();
        check("A done cleared", 64'(acc_done), 64'(0));

        // Three words, ready toggling, start dropped mid-run.
        start_run(3, n);
        for (int i = 0; i < 6; i++) tick(1'b1);
        acc_start = 1'b0;
        check("B busy after start drop", 64'(acc_busy), 64'(1));
        wait_done("B", 1'b1, d);
        check_stream(3, "B");
        check("B stall stability", 64'(stall_err), 64'(0));
        tick();
        check("B done cleared", 64'(acc_done), 64'(0));
        px_ready = 1'b1;

        // Zero words: straight to done, nothing streamed.
        start_run(0, n);
        tick();
        check("C busy at N", 64'(acc_busy), 64'(1));
        tick();
        check("C done at N+1", 64'(acc_done), 64'(1));
        tick();
        check("C done held", 64'(acc_done), 64'(1));
        acc_start = 1'b0;
        tick();
        check("C done cleared", 64'(acc_done), 64'(0));
        check("C no px_valid", 64'(valid_cnt), 64'(0));

        // Reset during word 1 of 3, then a fresh run from word 0.
        start_run(3, n);
        for (int i = 0; i < 60 && q_data.size() < 10; i++) tick();
        check("D reached word 1", 64'(q_data.size()), 64'(10));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("D async reset");
        acc_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("D idle after release", 64'(acc_busy), 64'(0));
        start_run(2, n);
        tick();
        check("D restart raddr", 64'(wm_raddr), 64'(0));
        wait_done("D", 1'b0, d);
        check_stream(2, "D");
        acc_start = 1'b0;
        tick();

        // Four words, always ready: bubble count depends on prefetch.
        start_run(4, n);
        wait_done("E", 1'b0, d);
        check("E last xfer edge", 64'(last_edge()), 64'(n + LAST4));
        check("E done edge", 64'(d), 64'(n + LAST4));
        check_stream(4, "E");
        acc_start = 1'b0;
        tick();
        check("E done cleared", 64'(acc_done), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
